// File: rtl/clk_div_switch_pkg.sv
// Shared definitions for the glitch-free clock divider/gater: state encoding,
// reserved ratio values and the high-phase length helper.
package clk_div_switch_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam int DIV_OFF  = 0;
    localparam int DIV_PASS = 1;

    // High-phase length (in source cycles) of a divide-by-n period.
    function automatic logic [31:0] div_high(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: posedge enable flop, negedge re-time flop, AND.
// The enable seen by the AND only changes while clk is low.
module clk_gate_cell (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic gclk
);

    logic en_p;
    logic en_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) en_p <= 1'b0;
        else       en_p <= en;
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) en_n <= 1'b0;
        else       en_n <= en_p;
    end

    assign gclk = clk & en_n;

endmodule

// File: rtl/clk_div_switch.sv
// Glitch-free programmable clock divider/gater (pass, divide-by-N, stopped).
// Optional macro CLK_DIV_DUTY50_EN: half-cycle stretch giving 50% duty for odd N.
module clk_div_switch
    import clk_div_switch_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clk_en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic [DIV_W-1:0] div_cur,
    output logic             clk_on,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] N_OFF  = DIV_W'(DIV_OFF);
    localparam logic [DIV_W-1:0] N_PASS = DIV_W'(DIV_PASS);
    localparam logic [DIV_W-1:0] N_ONE  = DIV_W'(1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] hi_cnt;
    logic             hold, hold_nxt;
    logic             ack_nxt;
    logic             div_q, div_q_nxt;
    logic             pass_en;
    logic             pass_clk;
    logic             take;
    logic             boundary;

    assign hi_cnt   = DIV_W'(div_high(32'(div_cur)));
    // A request still high during its own ack cycle is the old one, not a new one.
    assign take     = div_req & ~div_ack;
    assign boundary = (state == ST_OFF) || (!hold && (cnt == div_cur - N_ONE));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_cur;
        hold_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        div_q_nxt = 1'b0;
        pass_en   = 1'b0;

        if (state == ST_RUN && !hold) begin
            div_q_nxt = (cnt < hi_cnt);
            cnt_nxt   = cnt + N_ONE;
        end

        if (boundary) begin
            cnt_nxt = '0;
            if (take) begin
                div_nxt = div_val;
                ack_nxt = 1'b1;
            end
            if (!clk_en || div_nxt == N_OFF) begin
                state_nxt = ST_OFF;
            end else begin
                state_nxt = ST_RUN;
                // One idle cycle before the first pass pulse and between pass and divide.
                hold_nxt = (state == ST_OFF) ? (div_nxt == N_PASS)
                                             : (div_cur == N_PASS && div_nxt != N_PASS);
            end
        end

        pass_en = (state == ST_RUN) && (state_nxt == ST_RUN) && (div_nxt == N_PASS);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_OFF;
            cnt     <= '0;
            div_cur <= DIV_W'(DIV_RST);
            div_ack <= 1'b0;
            hold    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_cur <= div_nxt;
            div_ack <= ack_nxt;
            hold    <= hold_nxt;
            div_q   <= div_q_nxt;
        end
    end

    clk_gate_cell u_pass_gate (
        .clk  (clk),
        .rstn (rstn),
        .en   (pass_en),
        .gclk (pass_clk)
    );

    assign clk_on = (state == ST_RUN);

`ifdef CLK_DIV_DUTY50_EN
    logic div_n;
    logic odd_div;

    assign odd_div = div_cur[0] && (div_cur != N_PASS);

    // Re-timed copy of div_q stretches the high phase by half a cycle.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) div_n <= 1'b0;
        else       div_n <= div_q & odd_div;
    end

    assign clk_out = pass_clk | div_q | div_n;
`else
    assign clk_out = pass_clk | div_q;
`endif

endmodule

// File: tb/tb_clk_div_switch.sv
// Bench for clk_div_switch: directed scenarios then random traffic, checked
// against a period-level waveform model (queue of expected half-cycle levels).
`timescale 1ns/1ps
module tb_clk_div_switch;

    localparam int DIV_W   = 4;
    localparam int DIV_RST = 4;

    logic             clk     = 1'b0;
    logic             rstn    = 1'b1;
    logic             clk_en  = 1'b0;
    logic             div_req = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             div_ack;
    logic [DIV_W-1:0] div_cur;
    logic             clk_on;
    logic             clk_out;

    int checks   = 0;
    int failures = 0;

    // Expected clk_out per source cycle: bit1 = clk-high half, bit0 = clk-low half.
    logic [1:0] q[$];
    int         m_cur = DIV_RST;
    bit         m_run = 1'b0;
    bit         m_ack = 1'b0;
    logic [1:0] m_cyc = 2'b00;
    bit         sticky_ok = 1'b0;

    clk_div_switch #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .clk_en  (clk_en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_cur (div_cur),
        .clk_on  (clk_on),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_period(input int n);
        int h;
        h = n / 2;
        if (n == 1) begin
            q.push_back(2'b10);
        end else begin
            for (int c = 0; c < n; c++) begin
                if (c < h) q.push_back(2'b11);
`ifdef CLK_DIV_DUTY50_EN
                else if (c == h && (n % 2) == 1) q.push_back(2'b10);
`endif
                else q.push_back(2'b00);
            end
        end
    endfunction

    // Advance the model by one source cycle given the inputs seen at this posedge.
    function automatic void model_edge(input bit en, input bit req, input int val);
        bit bnd;
        bit take;
        bit was_run;
        int old_n;
        m_cyc   = (q.size() > 0) ? q.pop_front() : 2'b00;
        bnd     = m_run ? (q.size() == 0) : 1'b1;
        take    = req && !m_ack;
        m_ack   = 1'b0;
        if (bnd) begin
            old_n   = m_cur;
            was_run = m_run;
            if (take) begin
                m_cur = val;
                m_ack = 1'b1;
            end
            if (!en || m_cur == 0) begin
                m_run = 1'b0;
            end else begin
                if (!was_run && m_cur == 1) q.push_back(2'b00);
                if (was_run && old_n == 1 && m_cur >= 2) q.push_back(2'b00);
                push_period(m_cur);
                m_run = 1'b1;
            end
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_cur = DIV_RST;
        m_run = 1'b0;
        m_ack = 1'b0;
    endfunction

    task automatic step(input string tag);
        bit en_s;
        bit req_s;
        int val_s;
        en_s  = clk_en;
        req_s = div_req;
        val_s = int'(div_val);
        @(posedge clk);
        model_edge(en_s, req_s, val_s);
        #2;
        check({tag, " clk_out hi-half"}, 32'(clk_out), 32'(m_cyc[1]));
        check({tag, " div_ack"}, 32'(div_ack), 32'(m_ack));
        check({tag, " div_cur"}, 32'(div_cur), 32'(m_cur));
        check({tag, " clk_on"}, 32'(clk_on), 32'(m_run));
        @(negedge clk);
        #2;
        check({tag, " clk_out lo-half"}, 32'(clk_out), 32'(m_cyc[0]));
        if (m_ack && !(sticky_ok && $urandom_range(0, 3) == 0)) div_req = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic request(input int v);
        div_val = DIV_W'(v);
        div_req = 1'b1;
    endtask

    // Step until the model has just popped the first cycle of a period of length sz+1.
    task automatic seek(input int sz, input string tag);
        int guard;
        guard = 0;
        while (!(m_run && q.size() == sz) && guard < 64) begin
            step(tag);
            guard++;
        end
        check({tag, " seek bound"}, 32'(guard < 64), 32'd1);
    endtask

    task automatic reset_mid();
        int   guard;
        bit   en_s;
        bit   req_s;
        int   val_s;
        guard = 0;
        while (!(q.size() > 0 && q[0] == 2'b11) && guard < 64) begin
            step("rst seek");
            guard++;
        end
        check("rst seek bound", 32'(guard < 64), 32'd1);
        en_s  = clk_en;
        req_s = div_req;
        val_s = int'(div_val);
        @(posedge clk);
        model_edge(en_s, req_s, val_s);
        #2;
        check("rst pre clk_out", 32'(clk_out), 32'(m_cyc[1]));
        rstn = 1'b0;
        #1;
        model_reset();
        div_req = 1'b0;
        check("rst async clk_out", 32'(clk_out), 32'd0);
        check("rst async div_cur", 32'(div_cur), 32'(DIV_RST));
        check("rst async clk_on", 32'(clk_on), 32'd0);
        check("rst async div_ack", 32'(div_ack), 32'd0);
        @(negedge clk);
        #2;
        check("rst held clk_out", 32'(clk_out), 32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        #1 rstn = 1'b0;
        @(negedge clk);
        #2;
        check("reset clk_out", 32'(clk_out), 32'd0);
        check("reset div_ack", 32'(div_ack), 32'd0);
        check("reset clk_on", 32'(clk_on), 32'd0);
        check("reset div_cur", 32'(div_cur), 32'(DIV_RST));
        rstn = 1'b1;

        clk_en = 1'b1;
        run(14, "n4 run");

        seek(3, "n4 cnt1");
        request(3);
        run(12, "n4 to n3");

        request(2);
        run(10, "to n2");
        request(1);
        run(10, "n2 to pass");
        request(5);
        run(14, "pass to n5");

        request(6);
        run(14, "to n6");
        seek(6, "n6 cnt0");
        clk_en = 1'b0;
        run(10, "n6 stop");
        clk_en = 1'b1;
        run(10, "n6 restart");

        request(0);
        run(8, "to n0");
        request(4);
        run(6, "n0 to n4");
        reset_mid();
        run(10, "after reset");

        clk_en = 1'b0;
        request(2);
        run(10, "stop and change");
        clk_en = 1'b1;
        run(6, "restart n2");

        sticky_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!div_req && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 7) == 0) request($urandom_range(0, 15));
                else request($urandom_range(0, 6));
            end
            if ($urandom_range(0, 15) == 0) clk_en = ~clk_en;
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
